// File: rtl/stage5_merge_module_pkg.sv
// stage5_merge_module_pkg: shared widths, FIFO depth and helpers for the stage-5 merge block.
package stage5_merge_module_pkg;
  localparam int MAX_MESSAGE_BITS      = 32;
  localparam int N_TYPE_CONTROL_W      = 4;
  localparam int MESSAGE_MUX_CONTROL_W = 4;
  localparam int MERGE_FIFO_DEPTH      = 8;
  localparam int OVF_CNT_W             = 16;
  function automatic logic [1:0] cnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/stage5_merge_module_fifo.sv
// msg_fifo_3w1r_module: FIFO with three prefix-packed write ports and one read port.
module msg_fifo_3w1r_module
  import stage5_merge_module_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    wr_valid_i,
  input  logic [W-1:0]  wr_data_i [3],
  input  logic          admit_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    nwr;
  logic          pop;
  always_comb begin
    nwr      = admit_i ? cnt3(wr_valid_i) : 2'd0;
    pop      = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(nwr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(nwr) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is unreset; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (admit_i && wr_valid_i[k]) mem_q[wr_ptr_q + AW'(k)] <= wr_data_i[k];
  end
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/stage5_merge_module.sv
// stage5_merge_module: merges three parallel message slots into one in-order stream, dropping beats that do not fit.
module stage5_merge_module
  import stage5_merge_module_pkg::*;
#(
  parameter int MSG_W  = MAX_MESSAGE_BITS,
  parameter int TYPE_W = N_TYPE_CONTROL_W,
  parameter int MUX_W  = MESSAGE_MUX_CONTROL_W,
  parameter int DEPTH  = MERGE_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   message_en_in,
  input  logic [MSG_W-1:0]       message_1_in,
  input  logic [MSG_W-1:0]       message_2_in,
  input  logic [MSG_W-1:0]       message_3_in,
  input  logic [TYPE_W-1:0]      N_type_control_m1_in,
  input  logic [TYPE_W-1:0]      N_type_control_m2_in,
  input  logic [TYPE_W-1:0]      N_type_control_m3_in,
  input  logic [MUX_W-1:0]       message_mux_control_m1_in,
  input  logic [MUX_W-1:0]       message_mux_control_m2_in,
  input  logic [MUX_W-1:0]       message_mux_control_m3_in,
  output logic                   msg_valid_out,
  input  logic                   msg_ready_in,
  output logic [MSG_W-1:0]       msg_data_out,
  output logic [TYPE_W-1:0]      msg_type_out,
  output logic [MUX_W-1:0]       msg_mux_out,
  output logic                   almost_full_out,
  output logic [$clog2(DEPTH):0] level_out,
  output logic [OVF_CNT_W-1:0]   overflow_cnt_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = MUX_W + TYPE_W + MSG_W;
  logic [2:0]           present, wr_valid;
  logic [EW-1:0]        slot [3];
  logic [EW-1:0]        wr_data [3];
  logic [EW-1:0]        head;
  logic [1:0]           npush;
  logic [CW-1:0]        count, free;
  logic                 admit;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
  always_comb begin
    present = {message_mux_control_m3_in != '0, message_mux_control_m2_in != '0,
               message_mux_control_m1_in != '0} & {3{message_en_in}};
    slot[0] = {message_mux_control_m1_in, N_type_control_m1_in, message_1_in};
    slot[1] = {message_mux_control_m2_in, N_type_control_m2_in, message_2_in};
    slot[2] = {message_mux_control_m3_in, N_type_control_m3_in, message_3_in};
    npush   = cnt3(present);
    // Compaction: port k carries the (k+1)-th present slot in slot order.
    wr_data[0] = present[0] ? slot[0] : present[1] ? slot[1] : slot[2];
    wr_data[1] = (present[0] && present[1]) ? slot[1] : slot[2];
    wr_data[2] = slot[2];
    wr_valid   = {npush == 2'd3, npush >= 2'd2, npush >= 2'd1};
    free       = CW'(DEPTH) - count;
    admit      = CW'(npush) <= free;
    ovf_d      = (!admit && ovf_q != '1) ? ovf_q + OVF_CNT_W'(1) : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end
  msg_fifo_3w1r_module #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .admit_i    (admit),
    .rd_en_i    (msg_ready_in),
    .rd_data_o  (head),
    .count_o    (count)
  );
  assign msg_valid_out                            = count != '0;
  assign {msg_mux_out, msg_type_out, msg_data_out} = msg_valid_out ? head : '0;
  assign almost_full_out                          = free < CW'(3);
  assign level_out                                = count;
  assign overflow_cnt_out                         = ovf_q;
endmodule
